// File: rtl/player_input_conditioner_if.sv
// Pin bundle between one player's raw controls and the input conditioner.
// The master side drives the raw pins; the slave side returns the conditioned vector.
interface player_input_conditioner_if;
    logic       left_l;
    logic       right_l;
    logic       up_l;
    logic       down_l;
    logic       attack;
    logic       shield;
    logic [6:0] controller_inputs;

    modport master (
        output left_l, right_l, up_l, down_l, attack, shield,
        input  controller_inputs
    );

    modport slave (
        input  left_l, right_l, up_l, down_l, attack, shield,
        output controller_inputs
    );
endinterface

// File: rtl/player_input_conditioner.sv
// Per-player input front end: synchronise, debounce, SOCD-resolve and pulse-shape six buttons
// into the 7-bit controller vector consumed by the game core.
module player_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ATTACK_COOLDOWN = 25_000_000
) (
    input  logic                        clk,
    input  logic                        rst_l,
    player_input_conditioner_if.slave   pins
);
    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_ATTACK = 4;
    localparam int BTN_SHIELD = 5;

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int COOL_W = $clog2(ATTACK_COOLDOWN + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(ATTACK_COOLDOWN - 1);
    // Idle pin levels in button order: the four directions are active-low.
    localparam logic [5:0] RAW_RELEASED = 6'b001111;

    typedef enum logic [1:0] {
        ATK_IDLE,
        ATK_PULSE,
        ATK_COOL,
        ATK_WAIT_REL
    } atk_state_t;

    logic [5:0]        raw;
    logic [5:0]        sync_q [SYNC_STAGES];
    logic [5:0]        pressed;
    logic [5:0]        stable;
    logic [DEB_W-1:0]  deb_cnt [6];
    logic              up_q;
    logic              attack_q;
    logic              up_rise;
    logic              attack_rise;
    atk_state_t        atk_state;
    atk_state_t        atk_state_d;
    logic [COOL_W-1:0] cool_cnt;
    logic [COOL_W-1:0] cool_cnt_d;
    logic [5:0]        levels_d;
    logic [5:0]        prev_levels;
    logic [6:0]        ctrl_q;

    assign raw = {pins.shield, pins.attack, pins.down_l, pins.up_l, pins.right_l, pins.left_l};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RAW_RELEASED;
        end else begin
            sync_q[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign pressed = sync_q[SYNC_STAGES-1] ^ RAW_RELEASED;

    // A button flips only after disagreeing with its stable state for a full debounce window.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            stable   <= '0;
            up_q     <= 1'b0;
            attack_q <= 1'b0;
            for (int i = 0; i < 6; i++) deb_cnt[i] <= '0;
        end else begin
            up_q     <= stable[BTN_UP];
            attack_q <= stable[BTN_ATTACK];
            for (int i = 0; i < 6; i++) begin
                if (pressed[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign up_rise     = stable[BTN_UP] & ~up_q;
    assign attack_rise = stable[BTN_ATTACK] & ~attack_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            atk_state <= ATK_IDLE;
            cool_cnt  <= '0;
        end else begin
            atk_state <= atk_state_d;
            cool_cnt  <= cool_cnt_d;
        end
    end

    // Shield suppresses attack edges outright; after cooldown a held attack must be released first.
    always_comb begin
        atk_state_d = atk_state;
        cool_cnt_d  = cool_cnt;
        case (atk_state)
            ATK_IDLE: begin
                if (attack_rise && !stable[BTN_SHIELD]) atk_state_d = ATK_PULSE;
            end
            ATK_PULSE: begin
                cool_cnt_d  = '0;
                atk_state_d = ATK_COOL;
            end
            ATK_COOL: begin
                if (cool_cnt == COOL_LAST) begin
                    atk_state_d = stable[BTN_ATTACK] ? ATK_WAIT_REL : ATK_IDLE;
                end else begin
                    cool_cnt_d = cool_cnt + 1'b1;
                end
            end
            ATK_WAIT_REL: begin
                if (!stable[BTN_ATTACK]) atk_state_d = ATK_IDLE;
            end
            default: atk_state_d = ATK_IDLE;
        endcase
    end

    always_comb begin
        levels_d    = '0;
        levels_d[0] = stable[BTN_LEFT] & ~stable[BTN_RIGHT];
        levels_d[1] = stable[BTN_RIGHT] & ~stable[BTN_LEFT];
        levels_d[2] = up_rise & ~stable[BTN_DOWN];
        levels_d[3] = stable[BTN_DOWN] & ~stable[BTN_UP];
        levels_d[4] = (atk_state_d == ATK_PULSE);
        levels_d[5] = stable[BTN_SHIELD];
    end

    // The strobe compares the registered vector with its own previous value, so it trails by one cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ctrl_q      <= '0;
            prev_levels <= '0;
        end else begin
            ctrl_q[5:0] <= levels_d;
            ctrl_q[6]   <= (ctrl_q[5:0] != prev_levels);
            prev_levels <= ctrl_q[5:0];
        end
    end

    assign pins.controller_inputs = ctrl_q;
endmodule

// File: tb/tb_player_input_conditioner.sv
// Bench for player_input_conditioner: vector table, directed corner sequences and random traffic,
// all compared against a sliding-window / cooldown-window reference model.
module tb_player_input_conditioner;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int COOL = 10;
    localparam int HIST = SYNC + DEB;

    typedef struct {
        logic [5:0] pressed;
        int         hold;
        logic [6:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst_l;
    int   n_total = 0;
    int   n_bad   = 0;
    bit   chk_en  = 1'b0;

    logic [5:0] m_hist [HIST];
    logic [5:0] m_stable;
    logic [5:0] m_stable_prev;
    logic [5:0] m_prev_levels;
    logic [6:0] m_out;
    int         m_cyc;
    int         m_last_pulse;

    always #5 clk = ~clk;

    player_input_conditioner_if bus ();

    player_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .ATTACK_COOLDOWN (COOL)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .pins  (bus.slave)
    );

    task automatic check_output(input string name, input logic [6:0] actual, input logic [6:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        n_total++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] p);
        bus.left_l  = ~p[0];
        bus.right_l = ~p[1];
        bus.up_l    = ~p[2];
        bus.down_l  = ~p[3];
        bus.attack  = p[4];
        bus.shield  = p[5];
    endtask

    task automatic model_reset();
        for (int j = 0; j < HIST; j++) m_hist[j] = '0;
        m_stable      = '0;
        m_stable_prev = '0;
        m_prev_levels = '0;
        m_out         = '0;
        m_cyc         = 0;
        m_last_pulse  = -1000;
    endtask

    // A button flips once the last DEB synchronised samples all disagree with it; an attack
    // press is honoured only if no pulse occurred within the last COOL+2 cycles.
    task automatic model_edge();
        logic [5:0] raw_p;
        logic [5:0] lv;
        bit         up_rise;
        bit         atk_rise;
        bit         fire;
        bit         strobe;
        bit         all_diff;
        raw_p = {bus.shield, bus.attack, ~bus.down_l, ~bus.up_l, ~bus.right_l, ~bus.left_l};
        m_cyc++;
        up_rise  = m_stable[2] & ~m_stable_prev[2];
        atk_rise = m_stable[4] & ~m_stable_prev[4];
        fire     = atk_rise && !m_stable[5] && (m_cyc - m_last_pulse >= COOL + 2);
        if (fire) m_last_pulse = m_cyc;
        lv[0] = m_stable[0] & ~m_stable[1];
        lv[1] = m_stable[1] & ~m_stable[0];
        lv[2] = up_rise & ~m_stable[3];
        lv[3] = m_stable[3] & ~m_stable[2];
        lv[4] = fire;
        lv[5] = m_stable[5];
        strobe        = (m_out[5:0] != m_prev_levels);
        m_prev_levels = m_out[5:0];
        m_out         = {strobe, lv};
        m_stable_prev = m_stable;
        for (int j = HIST - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = raw_p;
        for (int b = 0; b < 6; b++) begin
            all_diff = 1'b1;
            for (int j = SYNC; j < HIST; j++) begin
                if (m_hist[j][b] == m_stable[b]) all_diff = 1'b0;
            end
            if (all_diff) m_stable[b] = ~m_stable[b];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_l) model_edge();
        @(negedge clk);
        if (chk_en) check_output("model", bus.controller_inputs, m_out);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic count_high(input int cycles, input int idx, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            step();
            if (bus.controller_inputs[idx]) cnt++;
        end
    endtask

    initial begin
        vec_t       vecs [12];
        int         cnt;
        int         cnt_b;
        int         acc;
        logic [5:0] cur;

        vecs[0]  = '{6'b000000, 12, 7'b0000000};
        vecs[1]  = '{6'b000001, 12, 7'b0000001};
        vecs[2]  = '{6'b000011, 12, 7'b0000000};
        vecs[3]  = '{6'b000010, 12, 7'b0000010};
        vecs[4]  = '{6'b001000, 12, 7'b0001000};
        vecs[5]  = '{6'b001100, 12, 7'b0000000};
        vecs[6]  = '{6'b000100, 12, 7'b0000000};
        vecs[7]  = '{6'b100000, 12, 7'b0100000};
        vecs[8]  = '{6'b110000, 12, 7'b0100000};
        vecs[9]  = '{6'b101001, 12, 7'b0101001};
        vecs[10] = '{6'b010010, 12, 7'b0000010};
        vecs[11] = '{6'b000000, 12, 7'b0000000};

        apply_stimulus(6'b000000);
        rst_l = 1'b1;
        #1;
        rst_l = 1'b0;
        model_reset();
        @(negedge clk);
        chk_en = 1'b1;
        steps(3);
        check_output("reset_state", bus.controller_inputs, 7'b0000000);
        rst_l = 1'b1;

        $display("[TB] vector table");
        for (int v = 0; v < 12; v++) begin
            apply_stimulus(vecs[v].pressed);
            steps(vecs[v].hold);
            check_output($sformatf("vector%0d", v), bus.controller_inputs, vecs[v].expected);
        end

        $display("[TB] reset behaviour");
        apply_stimulus(6'b100001);
        steps(12);
        check_output("pre_reset", bus.controller_inputs, 7'b0100001);
        apply_stimulus(6'b111111);
        @(posedge clk);
        model_edge();
        #2;
        rst_l = 1'b0;
        model_reset();
        #1;
        check_output("reset_immediate", bus.controller_inputs, 7'b0000000);
        apply_stimulus(6'b000001);
        steps(3);
        check_output("reset_held", bus.controller_inputs, 7'b0000000);
        rst_l = 1'b1;
        steps(6);
        check_output("release_latency_early", bus.controller_inputs, 7'b0000000);
        step();
        check_output("release_latency", bus.controller_inputs, 7'b0000001);
        step();
        check_output("release_strobe", bus.controller_inputs, 7'b1000001);

        $display("[TB] bounce");
        apply_stimulus(6'b000000);
        steps(12);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(6'b000001);
            count_high(2, 0, cnt);
            acc += cnt;
            apply_stimulus(6'b000000);
            count_high(2, 0, cnt);
            acc += cnt;
        end
        count_high(6, 0, cnt);
        acc += cnt;
        check_count("bounce_suppressed", acc, 0);
        apply_stimulus(6'b000001);
        steps(6);
        check_output("hold_early", bus.controller_inputs, 7'b0000000);
        step();
        check_output("hold_left", bus.controller_inputs, 7'b0000001);
        count_high(10, 6, cnt);
        check_count("hold_strobe_once", cnt, 1);

        $display("[TB] opposing directions");
        apply_stimulus(6'b000011);
        steps(12);
        check_output("socd_lr", bus.controller_inputs, 7'b0000000);
        apply_stimulus(6'b000001);
        steps(6);
        check_output("socd_release_early", bus.controller_inputs, 7'b0000000);
        step();
        check_output("socd_release_right", bus.controller_inputs, 7'b0000001);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b001100);
        count_high(15, 2, cnt);
        check_count("socd_no_jump", cnt, 0);
        check_output("socd_ud", bus.controller_inputs, 7'b0000000);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b000011);
        cnt = 0;
        cnt_b = 0;
        repeat (15) begin
            step();
            if (bus.controller_inputs[0]) cnt++;
            if (bus.controller_inputs[1]) cnt_b++;
        end
        check_count("socd_same_cycle_left", cnt, 0);
        check_count("socd_same_cycle_right", cnt_b, 0);
        apply_stimulus(6'b000000);
        steps(12);

        $display("[TB] attack rate limit");
        apply_stimulus(6'b010000);
        count_high(30, 4, cnt);
        check_count("attack_hold_one", cnt, 1);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b010000);
        count_high(5, 4, acc);
        apply_stimulus(6'b000000);
        count_high(6, 4, cnt);
        acc += cnt;
        apply_stimulus(6'b010000);
        count_high(19, 4, cnt);
        acc += cnt;
        check_count("attack_cooldown_repress", acc, 1);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b010000);
        count_high(12, 4, cnt);
        check_count("attack_after_idle", cnt, 1);
        apply_stimulus(6'b000000);
        steps(12);

        $display("[TB] shield priority");
        apply_stimulus(6'b100000);
        steps(12);
        apply_stimulus(6'b110000);
        count_high(15, 4, cnt);
        check_count("shield_blocks", cnt, 0);
        check_output("shield_level", bus.controller_inputs, 7'b0100000);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b010000);
        count_high(12, 4, cnt);
        check_count("attack_after_shield", cnt, 1);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b110000);
        count_high(15, 4, cnt);
        check_count("shield_attack_same_cycle", cnt, 0);
        apply_stimulus(6'b000000);
        steps(12);

        $display("[TB] jump and reset during cooldown");
        apply_stimulus(6'b000100);
        count_high(50, 2, cnt);
        check_count("jump_once", cnt, 1);
        apply_stimulus(6'b000000);
        steps(12);
        apply_stimulus(6'b010000);
        count_high(9, 4, cnt);
        check_count("cool_pulse_before_reset", cnt, 1);
        rst_l = 1'b0;
        model_reset();
        apply_stimulus(6'b000000);
        steps(3);
        rst_l = 1'b1;
        cnt = 0;
        cnt_b = 0;
        repeat (20) begin
            step();
            if (bus.controller_inputs[4]) cnt++;
            if (bus.controller_inputs[6]) cnt_b++;
        end
        check_count("reset_no_attack_pulse", cnt, 0);
        check_count("reset_no_strobe", cnt_b, 0);

        $display("[TB] random traffic");
        cur = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) cur = cur ^ 6'(1 << $urandom_range(0, 5));
            apply_stimulus(cur);
            if ($urandom_range(0, 799) == 0) begin
                rst_l = 1'b0;
                model_reset();
                steps(2);
                rst_l = 1'b1;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
